// File: rtl/sqvt_vpath_ctrl.sv
// sqvt_vpath_ctrl: square-wave sequencer for the analog voltage path.
// Emits alternating high/low levels with programmable phase lengths, drives a
// latch enable delayed by PIPE_LAT to line up with the path registers, and
// takes new settings through a valid/ready handshake. A setting offered while
// running is held in shadow registers and applied at the next period boundary.
// Optional macro SQVT_VPATH_CTRL_PERIOD_CNT_EN adds a 16-bit period counter
// output (period_count_o).
module sqvt_vpath_ctrl #(
    parameter int          PIPE_LAT   = 2,
    parameter int          CNT_W      = 16,
    parameter logic [11:0] IDLE_LEVEL = 12'h800
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    input  logic [11:0]      cfg_vhigh_i,
    input  logic [11:0]      cfg_vlow_i,
    input  logic [CNT_W-1:0] cfg_thigh_i,
    input  logic [CNT_W-1:0] cfg_tlow_i,
    output logic [11:0]      vout_o,
    output logic             ven_o,
    output logic             busy_o,
    output logic             period_done_o
`ifdef SQVT_VPATH_CTRL_PERIOD_CNT_EN
    ,
    output logic [15:0]      period_count_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DRAIN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [11:0]        act_vh_q, act_vh_d, act_vl_q, act_vl_d;
    logic [CNT_W-1:0]   act_th_q, act_th_d, act_tl_q, act_tl_d;
    logic [11:0]        sh_vh_q, sh_vh_d, sh_vl_q, sh_vl_d;
    logic [CNT_W-1:0]   sh_th_q, sh_th_d, sh_tl_q, sh_tl_d;
    logic               pending_q, pending_d;
    logic               stop_req_q, stop_req_d;
    logic [11:0]        vout_q, vout_d;
    logic [PIPE_LAT-1:0] en_pipe_q, en_pipe_d;
    logic               cfg_xfer;
    logic               start_acc;
    logic               period_done;
    logic [CNT_W-1:0]   th_sel, tl_sel;

    assign cfg_ready_o   = !pending_q;
    assign cfg_xfer      = cfg_valid_i && !pending_q;
    assign period_done   = (state_q == S_LOW) && (cnt_q == '0);
    assign period_done_o = period_done;
    assign vout_o        = vout_q;
    assign ven_o         = en_pipe_q[PIPE_LAT-1];
    assign busy_o        = (state_q != S_IDLE) || (|en_pipe_q);

    // Next-state, phase counter, config bookkeeping and the level to emit next.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_vh_d   = act_vh_q;
        act_vl_d   = act_vl_q;
        act_th_d   = act_th_q;
        act_tl_d   = act_tl_q;
        sh_vh_d    = sh_vh_q;
        sh_vl_d    = sh_vl_q;
        sh_th_d    = sh_th_q;
        sh_tl_d    = sh_tl_q;
        pending_d  = pending_q;
        stop_req_d = stop_req_q;
        start_acc  = 1'b0;
        vout_d     = IDLE_LEVEL;
        th_sel     = act_th_q;
        tl_sel     = act_tl_q;

        // While running, an accepted offer is parked until the period boundary.
        if (state_q != S_IDLE && cfg_xfer) begin
            sh_vh_d   = cfg_vhigh_i;
            sh_vl_d   = cfg_vlow_i;
            sh_th_d   = cfg_thigh_i;
            sh_tl_d   = cfg_tlow_i;
            pending_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cfg_xfer) begin
                    act_vh_d = cfg_vhigh_i;
                    act_vl_d = cfg_vlow_i;
                    act_th_d = cfg_thigh_i;
                    act_tl_d = cfg_tlow_i;
                end
                // A same-cycle offer wins over the stored lengths.
                th_sel = cfg_xfer ? cfg_thigh_i : act_th_q;
                tl_sel = cfg_xfer ? cfg_tlow_i  : act_tl_q;
                if (start_i && th_sel != '0 && tl_sel != '0) begin
                    state_d   = S_HIGH;
                    cnt_d     = th_sel - CNT_W'(1);
                    start_acc = 1'b1;
                end
            end
            S_HIGH: begin
                if (stop_i) stop_req_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                    cnt_d   = act_tl_q - CNT_W'(1);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_LOW: begin
                if (stop_i) stop_req_d = 1'b1;
                if (cnt_q == '0) begin
                    if (stop_req_q || stop_i) begin
                        state_d    = S_DRAIN;
                        cnt_d      = CNT_W'(PIPE_LAT - 1);
                        stop_req_d = 1'b0;
                    end else begin
                        state_d = S_HIGH;
                        // Shadow with a zero length is dropped; old values stay.
                        if (pending_q) begin
                            pending_d = 1'b0;
                            if (sh_th_q != '0 && sh_tl_q != '0) begin
                                act_vh_d = sh_vh_q;
                                act_vl_d = sh_vl_q;
                                act_th_d = sh_th_q;
                                act_tl_d = sh_tl_q;
                            end
                        end
                        cnt_d = act_th_d - CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    // A setting still parked at stop time becomes the active one.
                    if (pending_d) begin
                        act_vh_d  = sh_vh_d;
                        act_vl_d  = sh_vl_d;
                        act_th_d  = sh_th_d;
                        act_tl_d  = sh_tl_d;
                        pending_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        unique case (state_d)
            S_HIGH:  vout_d = act_vh_d;
            S_LOW:   vout_d = act_vl_d;
            default: vout_d = IDLE_LEVEL;
        endcase
    end

    // Enable delay line: raw enable is "not idle", shifted PIPE_LAT stages.
    always_comb begin
        en_pipe_d    = '0;
        en_pipe_d[0] = (state_q != S_IDLE);
        for (int i = 1; i < PIPE_LAT; i++) en_pipe_d[i] = en_pipe_q[i-1];
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            act_vh_q   <= '0;
            act_vl_q   <= '0;
            act_th_q   <= '0;
            act_tl_q   <= '0;
            sh_vh_q    <= '0;
            sh_vl_q    <= '0;
            sh_th_q    <= '0;
            sh_tl_q    <= '0;
            pending_q  <= 1'b0;
            stop_req_q <= 1'b0;
            vout_q     <= IDLE_LEVEL;
            en_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_vh_q   <= act_vh_d;
            act_vl_q   <= act_vl_d;
            act_th_q   <= act_th_d;
            act_tl_q   <= act_tl_d;
            sh_vh_q    <= sh_vh_d;
            sh_vl_q    <= sh_vl_d;
            sh_th_q    <= sh_th_d;
            sh_tl_q    <= sh_tl_d;
            pending_q  <= pending_d;
            stop_req_q <= stop_req_d;
            vout_q     <= vout_d;
            en_pipe_q  <= en_pipe_d;
        end
    end

`ifdef SQVT_VPATH_CTRL_PERIOD_CNT_EN
    logic [15:0] pcnt_q;
    assign period_count_o = pcnt_q;

    // Period counter: cleared on an accepted start, wraps naturally.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_acc) pcnt_q <= '0;
        else if (period_done)   pcnt_q <= pcnt_q + 16'd1;
    end
`endif

endmodule
